// File: rtl/vx_issue_perf_counters_pkg.sv
// ---------------------------------------------------------------------------
// vx_issue_perf_counters_pkg
//
// Shared definitions for the issue-stage performance counters:
//   - PERF_CTR_BITS : default width of every performance counter
//   - EX_BITS       : width of the execute-unit type field
//   - ex_type_e     : execute-unit encodings (ALU, LSU, CSR, FPU, GPU)
//   - issue_events_t: one cycle's worth of issue-side stall events
// ---------------------------------------------------------------------------
package vx_issue_perf_counters_pkg;

    localparam int PERF_CTR_BITS = 44;
    localparam int EX_BITS       = 3;
    localparam int NUM_EX_UNITS  = 5;

    typedef enum logic [EX_BITS-1:0] {
        EX_ALU = 3'd0,
        EX_LSU = 3'd1,
        EX_CSR = 3'd2,
        EX_FPU = 3'd3,
        EX_GPU = 3'd4
    } ex_type_e;

    // unit[t] is indexed by the ex_type_e value of the stalled unit.
    typedef struct packed {
        logic                    ibf;
        logic                    scb;
        logic [NUM_EX_UNITS-1:0] unit;
    } issue_events_t;

endpackage

// File: rtl/vx_perf_counter.sv
// ---------------------------------------------------------------------------
// vx_perf_counter
//
// Single free-running event counter. Increments by one on each cycle where
// inc is high, wraps silently modulo 2^WIDTH, and is cleared synchronously by
// clear (clear wins over inc). Asynchronous active-low reset.
//
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   clear   : synchronous clear to zero
//   inc     : add one this cycle
//   count   : current count, straight from the register
// ---------------------------------------------------------------------------
module vx_perf_counter #(
    parameter int WIDTH = 44
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (inc) begin
            // Natural modulo wrap: all-ones + 1 -> 0.
            count_next = count_reg + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/vx_issue_perf_counters.sv
// ---------------------------------------------------------------------------
// vx_issue_perf_counters
//
// Issue-stage stall counters. Each cycle the stall events of the ibuffer,
// scoreboard and each dispatch target unit are detected, registered for one
// stage, and then counted. A stall in cycle N therefore shows up in its
// counter in cycle N+2.
//
// Parameters:
//   CTR_WIDTH  : width of every counter output
//   FPU_ENABLE : 0 removes the FPU counter (fpu_stalls tied to 0)
//
// Ports:
//   clk, reset_n          : clock and asynchronous active-low reset
//   perf_enable           : events are only counted while high
//   perf_clear            : synchronous clear of counters and event stage
//   ibuf_valid_in/_ready  : decode -> ibuffer handshake
//   scb_valid_in/_ready   : ibuffer head -> scoreboard handshake
//   disp_valid_in         : instruction offered to dispatch
//   disp_ex_type_in       : target unit (ex_type_e; 5..7 never stall a unit)
//   unit_ready_in         : per-unit ready, indexed by ex_type
//   *_stalls              : cumulative stall cycle counts
// ---------------------------------------------------------------------------
module vx_issue_perf_counters
    import vx_issue_perf_counters_pkg::*;
#(
    parameter int CTR_WIDTH  = PERF_CTR_BITS,
    parameter int FPU_ENABLE = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    perf_enable,
    input  logic                    perf_clear,
    input  logic                    ibuf_valid_in,
    input  logic                    ibuf_ready_in,
    input  logic                    scb_valid_in,
    input  logic                    scb_ready_in,
    input  logic                    disp_valid_in,
    input  logic [EX_BITS-1:0]      disp_ex_type_in,
    input  logic [NUM_EX_UNITS-1:0] unit_ready_in,
    output logic [CTR_WIDTH-1:0]    ibf_stalls,
    output logic [CTR_WIDTH-1:0]    scb_stalls,
    output logic [CTR_WIDTH-1:0]    lsu_stalls,
    output logic [CTR_WIDTH-1:0]    csr_stalls,
    output logic [CTR_WIDTH-1:0]    alu_stalls,
    output logic [CTR_WIDTH-1:0]    fpu_stalls,
    output logic [CTR_WIDTH-1:0]    gpu_stalls
);

    logic                    ibf_ev;
    logic                    scb_ev;
    logic [NUM_EX_UNITS-1:0] unit_ev;
    issue_events_t           ev_next;
    issue_events_t           ev_reg;

    logic [CTR_WIDTH-1:0]    ibf_count;
    logic [CTR_WIDTH-1:0]    scb_count;
    logic [CTR_WIDTH-1:0]    unit_count [NUM_EX_UNITS];

    // ------------------------------------------------------------------
    // Event detection
    // ------------------------------------------------------------------
    assign ibf_ev = ibuf_valid_in & ~ibuf_ready_in;
    assign scb_ev = scb_valid_in & ~scb_ready_in;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_EX_UNITS; gi++) begin : g_unit
            localparam bit UNIT_ON = (gi != int'(EX_FPU)) || (FPU_ENABLE != 0);
            if (UNIT_ON) begin : g_on
                // ex_type values 5..7 match no index and so never stall a unit.
                assign unit_ev[gi] = disp_valid_in
                                   & (disp_ex_type_in == EX_BITS'(gi))
                                   & ~unit_ready_in[gi];

                vx_perf_counter #(
                    .WIDTH (CTR_WIDTH)
                ) u_unit_ctr (
                    .clk     (clk),
                    .reset_n (reset_n),
                    .clear   (perf_clear),
                    .inc     (ev_reg.unit[gi]),
                    .count   (unit_count[gi])
                );
            end else begin : g_off
                assign unit_ev[gi]    = 1'b0;
                assign unit_count[gi] = '0;
            end
        end
    endgenerate

    // perf_enable is folded in before the register so that it is sampled in
    // the same cycle as the stall it qualifies.
    always_comb begin
        ev_next = '0;
        if (perf_enable) begin
            ev_next.ibf  = ibf_ev;
            ev_next.scb  = scb_ev;
            ev_next.unit = unit_ev;
        end
    end

    // ------------------------------------------------------------------
    // One-stage event pipeline; clear flushes it together with the counters
    // so an event captured before the clear is never counted afterwards.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ev_reg <= '0;
        end else if (perf_clear) begin
            ev_reg <= '0;
        end else begin
            ev_reg <= ev_next;
        end
    end

    // ------------------------------------------------------------------
    // Ibuffer and scoreboard counters
    // ------------------------------------------------------------------
    vx_perf_counter #(
        .WIDTH (CTR_WIDTH)
    ) u_ibf_ctr (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (perf_clear),
        .inc     (ev_reg.ibf),
        .count   (ibf_count)
    );

    vx_perf_counter #(
        .WIDTH (CTR_WIDTH)
    ) u_scb_ctr (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (perf_clear),
        .inc     (ev_reg.scb),
        .count   (scb_count)
    );

    // ------------------------------------------------------------------
    // Outputs, all straight from counter registers
    // ------------------------------------------------------------------
    assign ibf_stalls = ibf_count;
    assign scb_stalls = scb_count;
    assign alu_stalls = unit_count[int'(EX_ALU)];
    assign lsu_stalls = unit_count[int'(EX_LSU)];
    assign csr_stalls = unit_count[int'(EX_CSR)];
    assign fpu_stalls = unit_count[int'(EX_FPU)];
    assign gpu_stalls = unit_count[int'(EX_GPU)];

endmodule

// File: tb/tb_vx_issue_perf_counters.sv
module tb_vx_issue_perf_counters;
    import vx_issue_perf_counters_pkg::*;

    localparam int          SW         = 4;
    localparam logic [63:0] MAIN_MASK  = (64'd1 << PERF_CTR_BITS) - 64'd1;
    localparam logic [63:0] SMALL_MASK = (64'd1 << SW) - 64'd1;

    // Model/counter index: 0..4 = unit by ex_type, 5 = ibf, 6 = scb
    localparam int I_IBF = 5;
    localparam int I_SCB = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, perf_enable, perf_clear;
    logic       ibv, ibr, scv, scr, dv;
    logic [2:0] dt;
    logic [4:0] ur;

    logic [PERF_CTR_BITS-1:0] m_ibf, m_scb, m_lsu, m_csr, m_alu, m_fpu, m_gpu;
    logic [SW-1:0]            s_ibf, s_scb, s_lsu, s_csr, s_alu, s_fpu, s_gpu;

    vx_issue_perf_counters dut (
        .clk(clk), .reset_n(reset_n), .perf_enable(perf_enable), .perf_clear(perf_clear),
        .ibuf_valid_in(ibv), .ibuf_ready_in(ibr), .scb_valid_in(scv), .scb_ready_in(scr),
        .disp_valid_in(dv), .disp_ex_type_in(dt), .unit_ready_in(ur),
        .ibf_stalls(m_ibf), .scb_stalls(m_scb), .lsu_stalls(m_lsu), .csr_stalls(m_csr),
        .alu_stalls(m_alu), .fpu_stalls(m_fpu), .gpu_stalls(m_gpu)
    );

    vx_issue_perf_counters #(.CTR_WIDTH(SW), .FPU_ENABLE(0)) dut_small (
        .clk(clk), .reset_n(reset_n), .perf_enable(perf_enable), .perf_clear(perf_clear),
        .ibuf_valid_in(ibv), .ibuf_ready_in(ibr), .scb_valid_in(scv), .scb_ready_in(scr),
        .disp_valid_in(dv), .disp_ex_type_in(dt), .unit_ready_in(ur),
        .ibf_stalls(s_ibf), .scb_stalls(s_scb), .lsu_stalls(s_lsu), .csr_stalls(s_csr),
        .alu_stalls(s_alu), .fpu_stalls(s_fpu), .gpu_stalls(s_gpu)
    );

    int checks = 0;
    int errors = 0;

    string nm [7] = '{"alu", "lsu", "csr", "fpu", "gpu", "ibf", "scb"};

    // ---------------- reference model ----------------
    // Each edge: events seen one cycle earlier are added; current events are
    // queued. Clear or reset empties both counters and the queue.
    logic [63:0] mc [7];
    logic [63:0] sc [7];
    logic [6:0]  pend_q [$];

    function automatic logic [6:0] cur_events();
        logic [6:0] e;
        e = '0;
        if (perf_enable) begin
            for (int t = 0; t < 5; t++)
                e[t] = dv && (int'(dt) == t) && !ur[t];
            e[I_IBF] = ibv && !ibr;
            e[I_SCB] = scv && !scr;
        end
        return e;
    endfunction

    task automatic model_zero();
        for (int i = 0; i < 7; i++) begin
            mc[i] = 64'd0;
            sc[i] = 64'd0;
        end
        pend_q.delete();
    endtask

    task automatic model_edge();
        logic [6:0] e;
        if (!reset_n || perf_clear) begin
            model_zero();
        end else begin
            if (pend_q.size() > 0) begin
                e = pend_q.pop_front();
                for (int i = 0; i < 7; i++) begin
                    mc[i] = (mc[i] + 64'(e[i])) & MAIN_MASK;
                    if (i != int'(EX_FPU))
                        sc[i] = (sc[i] + 64'(e[i])) & SMALL_MASK;
                end
            end
            pend_q.push_back(cur_events());
        end
    endtask

    function automatic logic [63:0] main_out(int i);
        case (i)
            0: return 64'(m_alu);
            1: return 64'(m_lsu);
            2: return 64'(m_csr);
            3: return 64'(m_fpu);
            4: return 64'(m_gpu);
            5: return 64'(m_ibf);
            default: return 64'(m_scb);
        endcase
    endfunction

    function automatic logic [63:0] small_out(int i);
        case (i)
            0: return 64'(s_alu);
            1: return 64'(s_lsu);
            2: return 64'(s_csr);
            3: return 64'(s_fpu);
            4: return 64'(s_gpu);
            5: return 64'(s_ibf);
            default: return 64'(s_scb);
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("%s_main_%s", tag, nm[i]), main_out(i), mc[i]);
            check($sformatf("%s_small_%s", tag, nm[i]), small_out(i), sc[i]);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic set_idle();
        ibv = 1'b0; ibr = 1'b1; scv = 1'b0; scr = 1'b1;
        dv = 1'b0; dt = 3'd0; ur = 5'b11111;
        perf_enable = 1'b1; perf_clear = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       ibv, ibr, scv, scr, dv;
        logic [2:0] dt;
        logic [4:0] ur;
        logic       en, clr;
        int         n;
        int         e_alu, e_lsu, e_csr, e_fpu, e_gpu, e_ibf, e_scb;
    } vec_t;

    function automatic vec_t mk(logic a_ibv, logic a_ibr, logic a_scv, logic a_scr, logic a_dv,
                                logic [2:0] a_dt, logic [4:0] a_ur, logic a_en, logic a_clr, int a_n,
                                int ea, int el, int ec, int ef, int eg, int ei, int es);
        vec_t v;
        v.ibv = a_ibv; v.ibr = a_ibr; v.scv = a_scv; v.scr = a_scr; v.dv = a_dv;
        v.dt = a_dt; v.ur = a_ur; v.en = a_en; v.clr = a_clr; v.n = a_n;
        v.e_alu = ea; v.e_lsu = el; v.e_csr = ec; v.e_fpu = ef; v.e_gpu = eg;
        v.e_ibf = ei; v.e_scb = es;
        return v;
    endfunction

    vec_t tbl [15];

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        //            ibv ibr scv scr dv dt     ur        en clr n   alu lsu csr fpu gpu ibf scb
        tbl[0]  = mk(1, 0, 0, 1, 0, 3'd0, 5'b11111, 1, 0, 1,  0, 0, 0, 0, 0, 0,  0);
        tbl[1]  = mk(1, 0, 0, 1, 0, 3'd0, 5'b11111, 1, 0, 1,  0, 0, 0, 0, 0, 1,  0);
        tbl[2]  = mk(1, 0, 0, 1, 0, 3'd0, 5'b11111, 1, 0, 8,  0, 0, 0, 0, 0, 9,  0);
        tbl[3]  = mk(1, 1, 0, 1, 0, 3'd0, 5'b11111, 1, 0, 2,  0, 0, 0, 0, 0, 10, 0);
        tbl[4]  = mk(0, 1, 0, 1, 0, 3'd0, 5'b11111, 1, 1, 1,  0, 0, 0, 0, 0, 0,  0);
        tbl[5]  = mk(0, 1, 0, 1, 1, 3'd1, 5'b11101, 1, 0, 3,  0, 2, 0, 0, 0, 0,  0);
        tbl[6]  = mk(0, 1, 0, 1, 1, 3'd7, 5'b11101, 1, 0, 4,  0, 3, 0, 0, 0, 0,  0);
        tbl[7]  = mk(0, 1, 0, 1, 0, 3'd0, 5'b11111, 1, 1, 1,  0, 0, 0, 0, 0, 0,  0);
        tbl[8]  = mk(1, 0, 1, 0, 1, 3'd4, 5'b00000, 1, 0, 5,  0, 0, 0, 0, 4, 4,  4);
        tbl[9]  = mk(0, 1, 0, 1, 0, 3'd0, 5'b11111, 1, 0, 1,  0, 0, 0, 0, 5, 5,  5);
        tbl[10] = mk(0, 1, 0, 1, 0, 3'd0, 5'b11111, 1, 1, 1,  0, 0, 0, 0, 0, 0,  0);
        tbl[11] = mk(1, 0, 0, 1, 0, 3'd0, 5'b11111, 0, 0, 3,  0, 0, 0, 0, 0, 0,  0);
        tbl[12] = mk(0, 1, 0, 1, 0, 3'd0, 5'b11111, 1, 0, 1,  0, 0, 0, 0, 0, 0,  0);
        tbl[13] = mk(0, 1, 0, 1, 1, 3'd2, 5'b11011, 1, 0, 2,  0, 0, 1, 0, 0, 0,  0);
        tbl[14] = mk(0, 1, 0, 1, 0, 3'd0, 5'b11111, 1, 0, 1,  0, 0, 2, 0, 0, 0,  0);

        // ---------------- reset ----------------
        set_idle();
        reset_n = 1'b0;
        model_zero();
        tick("reset");
        tick("reset");
        for (int i = 0; i < 7; i++) begin
            check($sformatf("reset_state_main_%s", nm[i]), main_out(i), 64'd0);
            check($sformatf("reset_state_small_%s", nm[i]), small_out(i), 64'd0);
        end
        $display("reset: outputs held at zero");
        #2 reset_n = 1'b1;
        tick("post_reset");

        // ---------------- table ----------------
        for (int r = 0; r < 15; r++) begin
            ibv = tbl[r].ibv; ibr = tbl[r].ibr; scv = tbl[r].scv; scr = tbl[r].scr;
            dv = tbl[r].dv; dt = tbl[r].dt; ur = tbl[r].ur;
            perf_enable = tbl[r].en; perf_clear = tbl[r].clr;
            for (int k = 0; k < tbl[r].n; k++) tick($sformatf("row%0d", r));
            check($sformatf("row%0d_alu", r), 64'(m_alu), 64'(tbl[r].e_alu));
            check($sformatf("row%0d_lsu", r), 64'(m_lsu), 64'(tbl[r].e_lsu));
            check($sformatf("row%0d_csr", r), 64'(m_csr), 64'(tbl[r].e_csr));
            check($sformatf("row%0d_fpu", r), 64'(m_fpu), 64'(tbl[r].e_fpu));
            check($sformatf("row%0d_gpu", r), 64'(m_gpu), 64'(tbl[r].e_gpu));
            check($sformatf("row%0d_ibf", r), 64'(m_ibf), 64'(tbl[r].e_ibf));
            check($sformatf("row%0d_scb", r), 64'(m_scb), 64'(tbl[r].e_scb));
            $display("row %0d: ibf=%0d scb=%0d alu=%0d lsu=%0d csr=%0d fpu=%0d gpu=%0d",
                     r, m_ibf, m_scb, m_alu, m_lsu, m_csr, m_fpu, m_gpu);
        end

        // ---------------- wrap on 4-bit build ----------------
        set_idle(); perf_clear = 1'b1; tick("clr"); perf_clear = 1'b0;
        dv = 1'b1; dt = 3'd0; ur = 5'b11110;
        repeat (17) tick("wrap");
        set_idle(); tick("wrap");
        check("wrap_small_alu", 64'(s_alu), 64'd1);
        check("wrap_main_alu", 64'(m_alu), 64'd17);
        $display("wrap: small alu=%0d main alu=%0d", s_alu, m_alu);

        // ---------------- clear during a continuous stall ----------------
        perf_clear = 1'b1; tick("clr"); perf_clear = 1'b0;
        ibv = 1'b1; ibr = 1'b0;
        repeat (21) tick("pre_clear");
        check("clr_before", 64'(m_ibf), 64'd20);
        perf_clear = 1'b1; tick("clear_edge");
        check("clr_zero", 64'(m_ibf), 64'd0);
        perf_clear = 1'b0; tick("flushed");
        check("clr_flushed", 64'(m_ibf), 64'd0);
        tick("resume");
        check("clr_resume1", 64'(m_ibf), 64'd1);
        tick("resume");
        check("clr_resume2", 64'(m_ibf), 64'd2);
        $display("clear: ibf resumed at %0d", m_ibf);

        // ---------------- FPU stalls, enabled vs disabled build ----------------
        set_idle(); perf_clear = 1'b1; tick("clr"); perf_clear = 1'b0;
        dv = 1'b1; dt = 3'd3; ur = 5'b10111;
        repeat (5) tick("fpu");
        set_idle(); tick("fpu");
        check("fpu_main", 64'(m_fpu), 64'd5);
        check("fpu_disabled", 64'(s_fpu), 64'd0);
        $display("fpu: main=%0d disabled=%0d", m_fpu, s_fpu);

        // ---------------- asynchronous reset mid-cycle ----------------
        ibv = 1'b1; ibr = 1'b0; scv = 1'b1; scr = 1'b0;
        dv = 1'b1; dt = 3'd1; ur = 5'b00000;
        repeat (4) tick("pre_arst");
        check("arst_before_ibf", 64'(m_ibf), 64'd3);
        #2 reset_n = 1'b0;
        model_zero();
        #1;
        for (int i = 0; i < 7; i++) begin
            check($sformatf("arst_main_%s", nm[i]), main_out(i), 64'd0);
            check($sformatf("arst_small_%s", nm[i]), small_out(i), 64'd0);
        end
        tick("arst_hold");
        tick("arst_hold");
        #2 reset_n = 1'b1;
        tick("arst_rel");
        check("arst_rel0", 64'(m_ibf), 64'd0);
        tick("arst_rel");
        check("arst_rel1", 64'(m_ibf), 64'd1);
        $display("async reset: ibf restarted at %0d", m_ibf);

        // ---------------- randomized vs model ----------------
        for (int c = 0; c < 400; c++) begin
            ibv = 1'($urandom); ibr = 1'($urandom);
            scv = 1'($urandom); scr = 1'($urandom);
            dv  = 1'($urandom); dt  = 3'($urandom);
            ur  = 5'($urandom);
            perf_enable = ($urandom_range(0, 7) != 0);
            perf_clear  = ($urandom_range(0, 31) == 0);
            tick($sformatf("rand%0d", c));
            $display("rand %0d: ibf=%0d scb=%0d alu=%0d lsu=%0d csr=%0d fpu=%0d gpu=%0d",
                     c, m_ibf, m_scb, m_alu, m_lsu, m_csr, m_fpu, m_gpu);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
